// File: rtl/fpu_frame_sequencer.sv
// fpu_frame_sequencer: assembles 9-byte UART frames (opcode, operand A, operand B,
// operands MSB-first) into FPU issue requests, waits for completion and holds the
// last result. Illegal opcodes (opcode[7:5] != 0) are discarded with a strobe.
// Optional build macro FPU_SEQ_TIMEOUT_EN adds a response watchdog of
// TIMEOUT_CYCLES WAIT cycles; without it WAIT lasts until fpu_done or rst.
module fpu_frame_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        flush,
  input  logic        clr_err,
  output logic        fpu_start,
  output logic [4:0]  fpu_opcode,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic [31:0] sp_result,
  output logic [4:0]  sp_flags,
  output logic        result_valid,
  output logic        busy,
  output logic        err_illegal,
  output logic        err_overrun,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BYTE = 4'd8;

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("fpu_frame_sequencer: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state;
  logic [3:0]  byte_cnt;
  logic [7:0]  opcode_q;
  logic        byte_take;

`ifdef FPU_SEQ_TIMEOUT_EN
  // Value of the WAIT counter during the last permitted WAIT cycle.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmr;
`else
  assign err_timeout = 1'b0;
`endif

  // Flush wins over a coincident byte; bytes outside COLLECT are dropped.
  assign byte_take  = (state == ST_COLLECT) && rx_valid && !flush;
  assign fpu_opcode = opcode_q[4:0];

  // Frame assembly: byte 0 is the opcode, bytes 1-4 shift into rs1, 5-8 into rs2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= 8'd0;
      fpu_rs1  <= 32'd0;
      fpu_rs2  <= 32'd0;
    end else if (byte_take) begin
      if (byte_cnt == 4'd0) begin
        opcode_q <= rx_byte;
      end else if (byte_cnt <= 4'd4) begin
        fpu_rs1 <= {fpu_rs1[23:0], rx_byte};
      end else begin
        fpu_rs2 <= {fpu_rs2[23:0], rx_byte};
      end
    end
  end

  // Sequencer FSM with its byte counter, issue strobe, busy and illegal strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_COLLECT;
      byte_cnt    <= 4'd0;
      fpu_start   <= 1'b0;
      busy        <= 1'b0;
      err_illegal <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
      tmr         <= 16'd0;
      err_timeout <= 1'b0;
`endif
    end else begin
      fpu_start   <= 1'b0;
      err_illegal <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
      // A timeout firing this cycle overrides the clear below.
      if (clr_err) begin
        err_timeout <= 1'b0;
      end
`endif
      case (state)
        ST_COLLECT: begin
          if (flush) begin
            byte_cnt <= 4'd0;
          end else if (rx_valid) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= 4'd0;
              // opcode_q already holds byte 0 of this frame.
              if (opcode_q[7:5] == 3'b000) begin
                state     <= ST_ISSUE;
                fpu_start <= 1'b1;
                busy      <= 1'b1;
              end else begin
                err_illegal <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef FPU_SEQ_TIMEOUT_EN
          tmr   <= 16'd0;
`endif
        end
        ST_WAIT: begin
          // Completion has priority over a watchdog expiring in the same cycle.
          if (fpu_done) begin
            state <= ST_COLLECT;
            busy  <= 1'b0;
          end
`ifdef FPU_SEQ_TIMEOUT_EN
          else if (tmr == TMO_LAST) begin
            state       <= ST_COLLECT;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            tmr <= tmr + 16'd1;
          end
`endif
        end
        default: begin
          state <= ST_COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result capture: only a completion seen in WAIT updates the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_result    <= 32'd0;
      sp_flags     <= 5'd0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if ((state == ST_WAIT) && fpu_done) begin
        sp_result    <= fpu_result;
        sp_flags     <= fpu_flags;
        result_valid <= 1'b1;
      end
    end
  end

  // Sticky overrun: a byte arriving while an operation is outstanding is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overrun <= 1'b0;
    end else if (rx_valid && (state != ST_COLLECT)) begin
      err_overrun <= 1'b1;
    end else if (clr_err) begin
      err_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_frame_sequencer.sv
// Testbench for fpu_frame_sequencer: table-driven frames, hand-written corner
// sequences and randomized frames checked against a byte-level frame model.
module tb_fpu_frame_sequencer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        flush = 1'b0;
  logic        clr_err = 1'b0;
  logic        fpu_start;
  logic [4:0]  fpu_opcode;
  logic [31:0] fpu_rs1;
  logic [31:0] fpu_rs2;
  logic        fpu_done = 1'b0;
  logic [31:0] fpu_result = 32'd0;
  logic [4:0]  fpu_flags = 5'd0;
  logic [31:0] sp_result;
  logic [4:0]  sp_flags;
  logic        result_valid;
  logic        busy;
  logic        err_illegal;
  logic        err_overrun;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  // Model of the held result.
  logic [31:0] m_res = 32'd0;
  logic [4:0]  m_flg = 5'd0;

  typedef struct {
    logic [71:0] frame;
    bit          legal;
    logic [4:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  fpu_frame_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .flush        (flush),
    .clr_err      (clr_err),
    .fpu_start    (fpu_start),
    .fpu_opcode   (fpu_opcode),
    .fpu_rs1      (fpu_rs1),
    .fpu_rs2      (fpu_rs2),
    .fpu_done     (fpu_done),
    .fpu_result   (fpu_result),
    .fpu_flags    (fpu_flags),
    .sp_result    (sp_result),
    .sp_flags     (sp_flags),
    .result_valid (result_valid),
    .busy         (busy),
    .err_illegal  (err_illegal),
    .err_overrun  (err_overrun),
    .err_timeout  (err_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends bytes first..8 of a frame with random idle gaps between them.
  task automatic send_bytes(input logic [71:0] f, input int first, input int gap_max);
    for (int i = first; i < 9; i++) begin
      send_byte(f[71-8*i -: 8]);
      if (i < 8 && gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " fpu_start"}, fpu_start, 0);
    chk({tag, " fpu_opcode"}, fpu_opcode, 0);
    chk({tag, " fpu_rs1"}, fpu_rs1, 0);
    chk({tag, " fpu_rs2"}, fpu_rs2, 0);
    chk({tag, " sp_result"}, sp_result, 0);
    chk({tag, " sp_flags"}, sp_flags, 0);
    chk({tag, " result_valid"}, result_valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " err_illegal"}, err_illegal, 0);
    chk({tag, " err_overrun"}, err_overrun, 0);
    chk({tag, " err_timeout"}, err_timeout, 0);
  endtask

  // Frame model: decode the nine bytes with plain arithmetic.
  function automatic void ref_frame(input logic [71:0] f, output bit legal,
                                    output logic [4:0] op, output logic [31:0] a,
                                    output logic [31:0] b);
    int unsigned by [9];
    for (int i = 0; i < 9; i++) by[i] = f[71-8*i -: 8];
    legal = (by[0] < 32);
    op    = 5'(by[0] % 32);
    a     = by[1] * 32'h0100_0000 + by[2] * 32'h0001_0000 + by[3] * 32'h100 + by[4];
    b     = by[5] * 32'h0100_0000 + by[6] * 32'h0001_0000 + by[7] * 32'h100 + by[8];
  endfunction

  // Sends a whole frame; for a legal one, completes it after lat WAIT cycles.
  task automatic run_frame(input string tag, input logic [71:0] f, input int gap_max,
                           input int lat, input bit legal, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [4:0] flg);
    send_bytes(f, 0, gap_max);
    if (legal) begin
      chk({tag, " start"}, fpu_start, 1);
      chk({tag, " busy issue"}, busy, 1);
      chk({tag, " opcode"}, fpu_opcode, op);
      chk({tag, " rs1"}, fpu_rs1, a);
      chk({tag, " rs2"}, fpu_rs2, b);
      tick();
      chk({tag, " start one cycle"}, fpu_start, 0);
      chk({tag, " busy wait"}, busy, 1);
      repeat (lat - 1) tick();
      chk({tag, " rs1 stable"}, fpu_rs1, a);
      chk({tag, " opcode stable"}, fpu_opcode, op);
      fpu_done = 1'b1; fpu_result = res; fpu_flags = flg;
      tick();
      fpu_done = 1'b0; fpu_result = 32'hFFFF_FFFF; fpu_flags = 5'h1F;
      m_res = res; m_flg = flg;
      chk({tag, " result_valid"}, result_valid, 1);
      chk({tag, " sp_result"}, sp_result, m_res);
      chk({tag, " sp_flags"}, sp_flags, m_flg);
      chk({tag, " busy done"}, busy, 0);
      tick();
      chk({tag, " result_valid one cycle"}, result_valid, 0);
      chk({tag, " sp_result held"}, sp_result, m_res);
    end else begin
      chk({tag, " err_illegal"}, err_illegal, 1);
      chk({tag, " no start"}, fpu_start, 0);
      chk({tag, " busy illegal"}, busy, 0);
      tick();
      chk({tag, " err_illegal one cycle"}, err_illegal, 0);
      chk({tag, " no start later"}, fpu_start, 0);
      chk({tag, " sp_result kept"}, sp_result, m_res);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit          legal;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [71:0] f;
    logic [7:0]  ob;

    tbl[0] = '{72'h00_3F800000_40000000, 1'b1, 5'h00, 32'h3F800000, 32'h40000000, 32'h40400000, 5'h00};
    tbl[1] = '{72'hE1_11223344_55667788, 1'b0, 5'h00, 32'h0, 32'h0, 32'h0, 5'h00};
    tbl[2] = '{72'h1F_DEADBEEF_01234567, 1'b1, 5'h1F, 32'hDEADBEEF, 32'h01234567, 32'h12345678, 5'h1F};
    tbl[3] = '{72'h20_AAAAAAAA_BBBBBBBB, 1'b0, 5'h00, 32'h0, 32'h0, 32'h0, 5'h00};
    tbl[4] = '{72'h05_FFFFFFFF_00000000, 1'b1, 5'h05, 32'hFFFFFFFF, 32'h00000000, 32'h7F800000, 5'h04};

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Table vectors
    foreach (tbl[i]) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].frame, 0, 1 + i, tbl[i].legal, tbl[i].op,
                tbl[i].rs1, tbl[i].rs2, tbl[i].res, tbl[i].flg);
    end

    // fpu_done outside WAIT is ignored
    fpu_done = 1'b1; fpu_result = 32'h0BAD_0BAD; fpu_flags = 5'h11;
    tick();
    fpu_done = 1'b0;
    chk("stray done result_valid", result_valid, 0);
    chk("stray done sp_result", sp_result, m_res);

    // Overrun during WAIT, clr_err coinciding with a new drop, byte in done cycle
    send_bytes(72'h01_11111111_22222222, 0, 0);
    chk("ovr start", fpu_start, 1);
    tick();
    send_byte(8'hAA);
    chk("ovr set", err_overrun, 1);
    chk("ovr still busy", busy, 1);
    rx_valid = 1'b1; rx_byte = 8'h55; clr_err = 1'b1;
    tick();
    rx_valid = 1'b0; clr_err = 1'b0;
    chk("ovr set beats clear", err_overrun, 1);
    rx_valid = 1'b1; rx_byte = 8'h66;
    fpu_done = 1'b1; fpu_result = 32'hCAFE_F00D; fpu_flags = 5'h03;
    tick();
    rx_valid = 1'b0; fpu_done = 1'b0;
    m_res = 32'hCAFE_F00D; m_flg = 5'h03;
    chk("ovr result_valid", result_valid, 1);
    chk("ovr sp_result", sp_result, m_res);
    chk("ovr busy", busy, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovr cleared", err_overrun, 0);
    run_frame("after ovr", tbl[0].frame, 0, 2, 1'b1, 5'h00, 32'h3F800000, 32'h40000000,
              32'h40400000, 5'h00);

    // Flush after 3 bytes, then a full frame
    send_bytes(72'h02_AABBCCDD_EEFF0011, 6, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_frame("post flush", 72'h03_12345678_9ABCDEF0, 1, 3, 1'b1, 5'h03, 32'h12345678,
              32'h9ABCDEF0, 32'h3F000000, 5'h01);

    // Flush together with a byte: the byte is discarded
    send_bytes(72'h04_01020304_05060708, 5, 0);
    rx_valid = 1'b1; rx_byte = 8'hEE; flush = 1'b1;
    tick();
    rx_valid = 1'b0; flush = 1'b0;
    run_frame("flush+byte", 72'h06_A1A2A3A4_B1B2B3B4, 0, 1, 1'b1, 5'h06, 32'hA1A2A3A4,
              32'hB1B2B3B4, 32'h00000001, 5'h08);

    // Flush in WAIT has no effect
    send_bytes(72'h07_00000007_00000008, 0, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush in wait busy", busy, 1);
    chk("flush in wait rs1", fpu_rs1, 32'h00000007);
    fpu_done = 1'b1; fpu_result = 32'h0000_0015; fpu_flags = 5'h00;
    tick();
    fpu_done = 1'b0;
    m_res = 32'h0000_0015; m_flg = 5'h00;
    chk("flush in wait result_valid", result_valid, 1);
    tick();

    // Reset after 5 frame bytes
    send_bytes(72'h00_3F800000_40000000, 4, 0);
    rst = 1'b1;
    #1;
    chk_all_zero("rst mid-frame");
    tick();
    rst = 1'b0;
    m_res = 32'd0; m_flg = 5'd0;
    run_frame("after rst", 72'h00_3F800000_40000000, 0, 1, 1'b1, 5'h00, 32'h3F800000,
              32'h40000000, 32'h40400000, 5'h00);

    // Reset in WAIT with overrun set: operation discarded, no result
    send_bytes(72'h02_11112222_33334444, 0, 0);
    tick();
    send_byte(8'h99);
    chk("pre-rst ovr", err_overrun, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst mid-wait");
    tick();
    rst = 1'b0;
    m_res = 32'd0; m_flg = 5'd0;
    fpu_done = 1'b1; fpu_result = 32'h5555_5555;
    tick();
    fpu_done = 1'b0;
    chk("rst wait no result_valid", result_valid, 0);
    chk("rst wait sp_result", sp_result, 0);

`ifdef FPU_SEQ_TIMEOUT_EN
    // Watchdog fires after TMO WAIT cycles without completion
    send_bytes(72'h01_00000001_00000002, 0, 0);
    chk("tmo start", fpu_start, 1);
    tick();
    repeat (TMO - 1) tick();
    chk("tmo last wait busy", busy, 1);
    chk("tmo not yet", err_timeout, 0);
    tick();
    chk("tmo fired", err_timeout, 1);
    chk("tmo busy", busy, 0);
    chk("tmo sp_result", sp_result, m_res);
    chk("tmo result_valid", result_valid, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo cleared", err_timeout, 0);
    // Completion on the last permitted cycle wins
    send_bytes(72'h01_00000001_00000002, 0, 0);
    tick();
    repeat (TMO - 1) tick();
    fpu_done = 1'b1; fpu_result = 32'h4040_4040; fpu_flags = 5'h02;
    tick();
    fpu_done = 1'b0;
    m_res = 32'h4040_4040; m_flg = 5'h02;
    chk("tmo edge result_valid", result_valid, 1);
    chk("tmo edge sp_result", sp_result, m_res);
    chk("tmo edge no timeout", err_timeout, 0);
    tick();
    chk("tmo edge still no timeout", err_timeout, 0);
`else
    // Without the watchdog WAIT persists until fpu_done
    send_bytes(72'h01_00000001_00000002, 0, 0);
    tick();
    repeat (3 * TMO) tick();
    chk("no tmo busy", busy, 1);
    chk("no tmo err", err_timeout, 0);
    fpu_done = 1'b1; fpu_result = 32'h4040_4040; fpu_flags = 5'h02;
    tick();
    fpu_done = 1'b0;
    m_res = 32'h4040_4040; m_flg = 5'h02;
    chk("no tmo result_valid", result_valid, 1);
    chk("no tmo sp_result", sp_result, m_res);
`endif

    // Randomized frames against the frame model
    for (int i = 0; i < 40; i++) begin
      ob = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      f  = {ob, $urandom(), $urandom()};
      ref_frame(f, legal, op, a, b);
      run_frame($sformatf("rnd%0d", i), f, 2, $urandom_range(1, 6), legal, op, a, b,
                $urandom(), 5'($urandom_range(0, 31)));
    end
    chk("final err_overrun", err_overrun, 0);
    chk("final err_timeout", err_timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_frame_sequencer.md
FPU_FRAME_SEQUENCER -- requirements
Module: fpu_frame_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of WAIT-state cycles allowed before the response watchdog fires (legal range 1..65535).
REQ-002 Port clk  input  1  single block clock; all state advances on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port rx_valid  input  1  one-cycle strobe marking a received UART byte.
REQ-005 Port rx_byte  input  8  received byte, valid when rx_valid=1.
REQ-006 Port flush  input  1  synchronous frame-resynchronisation request.
REQ-007 Port clr_err  input  1  clears the sticky error flags.
REQ-008 Port fpu_start  output  1  one-cycle issue strobe to the FPU.
REQ-009 Port fpu_opcode  output  5  FPU operation select.
REQ-010 Port fpu_rs1  output  32  operand A.
REQ-011 Port fpu_rs2  output  32  operand B.
REQ-012 Port fpu_done  input  1  FPU completion strobe.
REQ-013 Port fpu_result  input  32  FPU result, valid with fpu_done.
REQ-014 Port fpu_flags  input  5  IEEE exception flags, valid with fpu_done.
REQ-015 Port sp_result  output  32  last completed result, held until the next completion.
REQ-016 Port sp_flags  output  5  flags of the last completed operation.
REQ-017 Port result_valid  output  1  one-cycle strobe when sp_result is updated.
REQ-018 Port busy  output  1  high in the ISSUE and WAIT states.
REQ-019 Port err_illegal  output  1  one-cycle strobe on a discarded illegal-opcode frame.
REQ-020 Port err_overrun  output  1  sticky flag; a byte was dropped.
REQ-021 Port err_timeout  output  1  sticky flag; the watchdog fired.

Function
REQ-022 The frame SHALL be 9 bytes: an opcode byte, then operand A MSB-first (4 bytes), then operand B MSB-first (4 bytes).
REQ-023 The FSM SHALL have states COLLECT, ISSUE and WAIT, with a 4-bit byte counter (0..8) that is active in COLLECT only.
REQ-024 In COLLECT, each rx_valid byte SHALL shift into the opcode, rs1 or rs2 register selected by the byte counter, and the counter SHALL then increment.
REQ-025 When byte 9 is accepted in cycle N: if opcode[7:5]==0, the FSM SHALL enter ISSUE at N+1 with fpu_start=1 for exactly cycle N+1, and fpu_opcode=opcode[4:0].
REQ-026 When byte 9 is accepted in cycle N and opcode[7:5]!=0, err_illegal SHALL pulse at N+1, no issue SHALL occur, and the FSM SHALL stay in COLLECT with the counter at 0.
REQ-027 ISSUE SHALL always go to WAIT on the next cycle.
REQ-028 fpu_opcode, fpu_rs1 and fpu_rs2 SHALL stay stable from ISSUE until WAIT exits.
REQ-029 In WAIT, fpu_done=1 in cycle M SHALL load sp_result and sp_flags at M+1, pulse result_valid at M+1, and return the FSM to COLLECT at M+1.
REQ-030 fpu_done outside WAIT SHALL be ignored.
REQ-031 rx_valid in ISSUE or WAIT, including the cycle of fpu_done, SHALL drop the byte and set err_overrun.
REQ-032 flush SHALL zero the byte counter in COLLECT.
REQ-033 flush in ISSUE or WAIT SHALL have no effect.
REQ-034 flush and rx_valid in the same COLLECT cycle: flush SHALL win and the byte SHALL be discarded.
REQ-035 clr_err SHALL clear err_overrun and err_timeout.
REQ-036 A set event coinciding with clr_err SHALL win, leaving its flag set.

Reset
REQ-037 rst=1 SHALL immediately force: FSM to COLLECT; counter to 0; all operand and opcode registers to 0; sp_result and sp_flags to 0; every strobe and error output to 0.
REQ-038 Reset mid-frame or mid-WAIT SHALL discard the partial frame or outstanding operation, with no result_valid.

Configuration
REQ-039 With macro FPU_SEQ_TIMEOUT_EN defined, a 16-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-040 With FPU_SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without fpu_done SHALL set err_timeout and return the FSM to COLLECT, leaving sp_result unchanged.
REQ-041 fpu_done in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally with no timeout.
REQ-042 Without FPU_SEQ_TIMEOUT_EN, no counter SHALL exist, err_timeout SHALL be tied 0, and WAIT SHALL persist until fpu_done or rst.

Verification
REQ-043 Bytes 00,3F,80,00,00,40,00,00,00 -> fpu_start 1 cycle after the last byte, with opcode 0x00, rs1=0x3F800000, rs2=0x40000000; fpu_done with result 0x40400000 and flags 0 -> sp_result=0x40400000 and result_valid pulse on the next cycle.
REQ-044 Opcode byte 0xE1 plus 8 operand bytes -> err_illegal pulse and no fpu_start; the next valid frame issues normally.
REQ-045 A byte during WAIT -> err_overrun=1 and the result is still delivered; clr_err -> err_overrun=0.
REQ-046 With TIMEOUT_CYCLES=16, FPU_SEQ_TIMEOUT_EN defined and no fpu_done -> err_timeout set 16 WAIT cycles after entry, busy=0, sp_result unchanged; a repeat with fpu_done on cycle 16 -> normal completion with no timeout.
REQ-047 rst asserted after 5 frame bytes -> all outputs 0; a fresh 9-byte frame then issues correctly.
REQ-048 flush after 3 bytes, then a 9-byte frame -> the operands match the post-flush bytes exactly.
